teacher: RTL and testbench
==========================

TEACHER -- requirements
Module: teacher

Interface
REQ-001 Parameter SCALE, default 0, left shift applied to the raw error; legal range 0..7.
REQ-002 Parameter SAMPLES, default 4, samples per epoch; legal range 1..255.
REQ-003 clk  in  1  Single clock; all state updates on the rising edge.
REQ-004 rst  in  1  Reset, asynchronous and active-low.
REQ-005 en  in  1  Enable; low freezes all state.
REQ-006 res_stb  in  1  Perceptron result valid.
REQ-007 res_dat  in  8  Perceptron result, unsigned.
REQ-008 res_rdy  out  1  Result accepted.
REQ-009 tgt_stb  in  1  Target label valid.
REQ-010 tgt_dat  in  8  Target label, unsigned.
REQ-011 tgt_rdy  out  1  Target accepted.
REQ-012 err_stb  out  1  Error valid, toward the perceptron err port.
REQ-013 err_dat  out  16  Error, two's complement.
REQ-014 err_rdy  in  1  Error accepted.
REQ-015 done  out  1  Sticky flag: a full epoch completed with zero error.
REQ-016 cnt_dat  out  16  Mismatch count (see Configuration).

Function
REQ-017 Each stream SHALL transfer on a rising edge where stb=1, rdy=1 and en=1.
REQ-018 A stb, once raised, SHALL be held until the transfer; dat SHALL be stable while stb=1 (this is an upstream obligation; the block does not check it).
REQ-019 The block SHALL hold a result register and a target register, each with its own valid flag.
- rdy = en & ~valid for each register.
- The two streams are accepted independently, in either order or in the same cycle.
REQ-020 The FSM SHALL have three states: IDLE, CALC and SEND.
- IDLE -> CALC when both valid flags are set.
- CALC -> SEND unconditionally after one cycle.
- SEND -> IDLE on the err transfer.
REQ-021 In CALC the block SHALL compute err_dat = sign-extend(tgt - res, 9 bits to 16 bits) << SCALE and register it.
- No saturation is needed: |err| <= 255*128 = 32640.
REQ-022 err_stb SHALL be 1 exactly in SEND; err_dat SHALL be stable throughout SEND.
REQ-023 A zero error SHALL still be sent, so every sample produces exactly one err transfer.
REQ-024 On the err transfer:
- both valid flags clear;
- the sample counter increments;
- the clean flag clears if err_dat != 0.
REQ-025 When the sample counter reaches SAMPLES:
- it wraps to 0;
- if clean=1, done is set;
- clean is then re-armed to 1.
REQ-026 done SHALL stay 1 until reset.
REQ-027 Latency: with both inputs transferred in cycle N, err_stb SHALL be 1 in cycle N+2.
REQ-028 While en=0:
- FSM, valid flags and counters hold;
- res_rdy = tgt_rdy = 0;
- err_stb and err_dat hold their values;
- a pending err transfer does not complete.
REQ-029 In SEND both rdys SHALL be 0, so the next sample's inputs cannot arrive early.

Reset
REQ-030 Asserting rst SHALL immediately force the following, with no clock required, including mid-SEND:
- FSM to IDLE;
- valid flags, sample counter and cnt_dat to 0;
- clean to 1;
- err_stb, err_dat and done to 0.
REQ-031 After rst deasserts, res_rdy and tgt_rdy SHALL be 1 on the first edge where en=1.

Configuration
REQ-032 With macro TEACHER_STATS_EN defined:
- cnt_dat increments on each err transfer with err_dat != 0;
- it saturates at 16'hFFFF and never wraps.
REQ-033 Without TEACHER_STATS_EN, cnt_dat SHALL be constant 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-034 Single sample, SCALE=0: res=8'h00, tgt=8'hFF in the same cycle N -> err_stb=1 at N+2 with err_dat=16'h00FF.
REQ-035 Ordering: tgt=8'h00 first, res=8'hFF three cycles later -> tgt_rdy=0 after its transfer; err_dat=16'hFF01; exactly one err transfer.
REQ-036 SCALE=7, res=8'hFF, tgt=8'h00 -> err_dat=16'h8080 (-32640).
REQ-037 Backpressure: hold err_rdy=0 for 5 cycles in SEND -> err_stb and err_dat stable, both rdys 0; transfer occurs on the first err_rdy=1 edge.
REQ-038 Epochs, SAMPLES=4, TEACHER_STATS_EN defined:
- epoch 1 with one mismatch -> done=0, cnt_dat=1;
- epoch 2 with all errors 0 -> done=1 after its 4th err transfer, cnt_dat=1.
REQ-039 Async reset and enable:
- rst low mid-SEND -> err_stb=0 before the next edge;
- en=0 for 3 cycles -> no transfers, state held.

Source files
------------

// File: rtl/teacher_if.sv
// Purpose: handshake bundle between the teacher and its perceptron-side
//          environment.
//   res_stb/res_dat/res_rdy : perceptron result stream (into the teacher)
//   tgt_stb/tgt_dat/tgt_rdy : target label stream (into the teacher)
//   err_stb/err_dat/err_rdy : signed error stream (out of the teacher)
// The slave modport is the teacher's view. The master modport is the
// environment's view: it produces results and targets and consumes errors.
interface teacher_if;
   logic        res_stb;
   logic [7:0]  res_dat;
   logic        res_rdy;
   logic        tgt_stb;
   logic [7:0]  tgt_dat;
   logic        tgt_rdy;
   logic        err_stb;
   logic [15:0] err_dat;
   logic        err_rdy;

   modport slave (
      input  res_stb, res_dat, tgt_stb, tgt_dat, err_rdy,
      output res_rdy, tgt_rdy, err_stb, err_dat
   );

   modport master (
      output res_stb, res_dat, tgt_stb, tgt_dat, err_rdy,
      input  res_rdy, tgt_rdy, err_stb, err_dat
   );
endinterface

// File: rtl/teacher.sv
// Purpose: training supervisor for a perceptron. It collects one result and
//          one target, sends back err = sext(tgt - res) << SCALE, and counts
//          samples per epoch. The sticky done flag is raised after an epoch
//          whose errors were all zero.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous, active-low reset
//   en      : enable; low freezes all state and blocks every transfer
//   bus     : teacher_if.slave (res/tgt streams in, err stream out)
//   done    : sticky "clean epoch seen" flag
//   cnt_dat : saturating count of non-zero errors sent
// Optional feature: define TEACHER_STATS_EN to build the mismatch counter.
//   Without it, cnt_dat is tied to zero.
module teacher #(
   parameter int unsigned SCALE   = 0,
   parameter int unsigned SAMPLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   teacher_if.slave      bus,
   output logic          done,
   output logic [15:0]   cnt_dat
);

   localparam int unsigned DAT_W = 8;
   localparam int unsigned ERR_W = 16;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

   state_t             state_q, state_d;
   logic               res_v_q, tgt_v_q;
   logic               res_v_d, tgt_v_d;
   logic [DAT_W-1:0]   res_q, tgt_q;
   logic               err_stb_q;
   logic [ERR_W-1:0]   err_dat_q;
   logic [CNT_W-1:0]   samp_q;
   logic               clean_q;
   logic               done_q;

   logic               res_xfer, tgt_xfer, err_xfer;
   logic               err_zero;
   logic [DAT_W:0]     diff;
   logic [ERR_W-1:0]   err_calc;

   // Each register accepts a new value only while it is empty.
   assign bus.res_rdy = en & ~res_v_q;
   assign bus.tgt_rdy = en & ~tgt_v_q;
   assign bus.err_stb = err_stb_q;
   assign bus.err_dat = err_dat_q;
   assign done        = done_q;

   assign res_xfer = bus.res_stb & bus.res_rdy & en;
   assign tgt_xfer = bus.tgt_stb & bus.tgt_rdy & en;
   assign err_xfer = bus.err_stb & bus.err_rdy & en;
   assign err_zero = (err_dat_q == '0);

   // 9-bit signed difference, sign-extended to 16 bits and then scaled.
   assign diff     = {1'b0, tgt_q} - {1'b0, res_q};
   assign err_calc = {{(ERR_W-DAT_W-1){diff[DAT_W]}}, diff} << SCALE;

   // Next-state and next-valid logic. IDLE leaves on the edge that makes
   // both flags valid, so err_stb rises two cycles after the last input.
   always_comb begin
      state_d = state_q;
      res_v_d = res_v_q;
      tgt_v_d = tgt_v_q;
      if (err_xfer) begin
         res_v_d = 1'b0;
         tgt_v_d = 1'b0;
      end else begin
         if (res_xfer) res_v_d = 1'b1;
         if (tgt_xfer) tgt_v_d = 1'b1;
      end
      case (state_q)
         IDLE:    if (en && res_v_d && tgt_v_d) state_d = CALC;
         CALC:    if (en) state_d = SEND;
         SEND:    if (err_xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else if (en) state_q <= state_d;
   end

   // Input registers and valid flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_v_q <= 1'b0;
         tgt_v_q <= 1'b0;
         res_q   <= '0;
         tgt_q   <= '0;
      end else if (en) begin
         res_v_q <= res_v_d;
         tgt_v_q <= tgt_v_d;
         if (res_xfer) res_q <= bus.res_dat;
         if (tgt_xfer) tgt_q <= bus.tgt_dat;
      end
   end

   // Error output registers. The error is captured in CALC and stays put
   // for the whole of SEND.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_stb_q <= 1'b0;
         err_dat_q <= '0;
      end else if (en) begin
         err_stb_q <= (state_d == SEND);
         if (state_q == CALC) err_dat_q <= err_calc;
      end
   end

   // Epoch bookkeeping. On the last sample, the clean test folds in the
   // current error before the flag is re-armed for the next epoch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp_q  <= '0;
         clean_q <= 1'b1;
         done_q  <= 1'b0;
      end else if (err_xfer) begin
         if (samp_q == CNT_W'(SAMPLES - 1)) begin
            samp_q  <= '0;
            clean_q <= 1'b1;
            if (clean_q && err_zero) done_q <= 1'b1;
         end else begin
            samp_q <= samp_q + CNT_W'(1);
            if (!err_zero) clean_q <= 1'b0;
         end
      end
   end

`ifdef TEACHER_STATS_EN
   logic [15:0] cnt_q;

   // Saturating count of non-zero errors sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else if (err_xfer && !err_zero && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
   end

   assign cnt_dat = cnt_q;
`else
   assign cnt_dat = '0;
`endif

endmodule

// File: tb/tb_teacher.sv
// Purpose: self-checking bench for teacher. It runs a table of single
//          samples, hand-written multi-cycle corner cases, and randomized
//          samples checked against a transaction-level model.
module tb_teacher;
   localparam int unsigned SAMPLES = 4;
`ifdef TEACHER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b1;
   always #5 clk = ~clk;

   teacher_if bus0 ();
   teacher_if bus7 ();
   logic        done0, done7;
   logic [15:0] cnt0, cnt7;

   teacher #(.SCALE(0), .SAMPLES(SAMPLES)) u_dut (
      .clk(clk), .rst(rst), .en(en), .bus(bus0), .done(done0), .cnt_dat(cnt0));
   teacher #(.SCALE(7), .SAMPLES(SAMPLES)) u_dut7 (
      .clk(clk), .rst(rst), .en(en), .bus(bus7), .done(done7), .cnt_dat(cnt7));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: which inputs are held, the epoch's progress,
   // the clean/done flags and the mismatch count.
   bit          mon_on = 1'b0;
   bit          m_res_v, m_tgt_v, m_clean, m_done;
   int          m_res, m_tgt, m_samp, m_cnt, m_xfers;
   logic [15:0] m_e;

   function automatic logic [15:0] model_err(input int t, input int r, input int sc);
      int e;
      e = (t - r) * (1 << sc);
      return 16'(e);
   endfunction

   task automatic model_reset();
      m_res_v = 0; m_tgt_v = 0; m_clean = 1; m_done = 0;
      m_res = 0; m_tgt = 0; m_samp = 0; m_cnt = 0;
   endtask

   // Monitor: compare on the falling edge, then apply the transfers that
   // the coming rising edge will perform.
   always @(negedge clk) begin
      if (!rst) begin
         model_reset();
      end else if (mon_on) begin
         chk("mon_res_rdy", bus0.res_rdy, en & ~m_res_v);
         chk("mon_tgt_rdy", bus0.tgt_rdy, en & ~m_tgt_v);
         chk("mon_done", done0, m_done);
         chk("mon_cnt", cnt0, STATS ? m_cnt : 0);
         if (bus0.err_stb) begin
            chk("mon_stb_without_inputs", m_res_v & m_tgt_v, 1);
            chk("mon_err_dat", bus0.err_dat, model_err(m_tgt, m_res, 0));
         end
         if (en && bus0.err_stb && bus0.err_rdy) begin
            m_e = model_err(m_tgt, m_res, 0);
            m_xfers++;
            m_res_v = 0;
            m_tgt_v = 0;
            if (m_e != 0) begin
               m_clean = 0;
               if (m_cnt < 65535) m_cnt++;
            end
            m_samp++;
            if (m_samp == SAMPLES) begin
               m_samp = 0;
               if (m_clean) m_done = 1;
               m_clean = 1;
            end
         end
         if (en && bus0.res_stb && bus0.res_rdy) begin m_res_v = 1; m_res = int'(bus0.res_dat); end
         if (en && bus0.tgt_stb && bus0.tgt_rdy) begin m_tgt_v = 1; m_tgt = int'(bus0.tgt_dat); end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_err(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus0.err_stb) begin ok = 1; break; end
         tick();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 0;
      @(negedge clk);
      @(posedge clk); #3;
      rst = 1;
      tick();
   endtask

   // Drive one sample through bus0; optionally randomize en and err_rdy.
   task automatic run_sample(input logic [7:0] r, input logic [7:0] t, input int gap_r,
                             input int gap_t, input bit rnd, output logic [15:0] got);
      bit r_done = 0, t_done = 0, e_done = 0;
      bit rx, tx, ex;
      int cyc = 0;
      got = '0;
      while (!e_done && cyc < 300) begin
         if (!r_done && cyc >= gap_r) begin bus0.res_stb = 1; bus0.res_dat = r; end
         if (!t_done && cyc >= gap_t) begin bus0.tgt_stb = 1; bus0.tgt_dat = t; end
         bus0.err_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         en = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
         @(negedge clk);
         rx = en & bus0.res_stb & bus0.res_rdy;
         tx = en & bus0.tgt_stb & bus0.tgt_rdy;
         ex = en & bus0.err_stb & bus0.err_rdy;
         if (ex) got = bus0.err_dat;
         tick();
         if (rx) begin r_done = 1; bus0.res_stb = 0; end
         if (tx) begin t_done = 1; bus0.tgt_stb = 0; end
         if (ex) e_done = 1;
         cyc++;
      end
      chk("sample_timeout", e_done, 1);
      bus0.err_rdy = 0;
      en = 1;
   endtask

   // One sample on the SCALE=7 instance.
   task automatic run7(input logic [7:0] r, input logic [7:0] t, input logic [15:0] exp);
      bit ok = 0;
      bus7.res_stb = 1; bus7.res_dat = r;
      bus7.tgt_stb = 1; bus7.tgt_dat = t;
      bus7.err_rdy = 1;
      tick();
      bus7.res_stb = 0; bus7.tgt_stb = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus7.err_stb) begin ok = 1; break; end
         tick();
      end
      chk("s7_timeout", ok, 1);
      chk("s7_err_dat", bus7.err_dat, exp);
      tick();
      chk("s7_stb_after_xfer", bus7.err_stb, 0);
      bus7.err_rdy = 0;
   endtask

   typedef struct {
      logic [7:0]  res;
      logic [7:0]  tgt;
      int          gap_r;
      int          gap_t;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs [8];
   logic [15:0] got;
   bit          ok;
   int          x0;
   logic [7:0]  rr, tt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h00, 8'hFF, 0, 0, 16'h00FF};
      vecs[1] = '{8'hFF, 8'h00, 3, 0, 16'hFF01};
      vecs[2] = '{8'h80, 8'h80, 0, 1, 16'h0000};
      vecs[3] = '{8'h01, 8'h00, 1, 0, 16'hFFFF};
      vecs[4] = '{8'h00, 8'h01, 0, 2, 16'h0001};
      vecs[5] = '{8'h7F, 8'h80, 2, 2, 16'h0001};
      vecs[6] = '{8'h80, 8'h7F, 0, 0, 16'hFFFF};
      vecs[7] = '{8'h10, 8'hF0, 4, 1, 16'h00E0};

      {bus0.res_stb, bus0.tgt_stb, bus0.err_rdy} = '0;
      {bus7.res_stb, bus7.tgt_stb, bus7.err_rdy} = '0;
      bus0.res_dat = '0; bus0.tgt_dat = '0;
      bus7.res_dat = '0; bus7.tgt_dat = '0;
      m_xfers = 0;

      // Reset state.
      #12;
      chk("rst_err_stb", bus0.err_stb, 0);
      chk("rst_err_dat", bus0.err_dat, 0);
      chk("rst_done", done0, 0);
      chk("rst_cnt", cnt0, 0);
      #10 rst = 1;
      tick();
      chk("rst_res_rdy", bus0.res_rdy, 1);
      chk("rst_tgt_rdy", bus0.tgt_rdy, 1);
      mon_on = 1;

      // Latency from a same-cycle input pair, then 5 cycles of backpressure.
      bus0.res_stb = 1; bus0.res_dat = 8'h00;
      bus0.tgt_stb = 1; bus0.tgt_dat = 8'hFF;
      bus0.err_rdy = 0;
      tick();
      bus0.res_stb = 0; bus0.tgt_stb = 0;
      chk("lat_n1_stb", bus0.err_stb, 0);
      chk("lat_n1_res_rdy", bus0.res_rdy, 0);
      tick();
      chk("lat_n2_stb", bus0.err_stb, 1);
      chk("lat_n2_dat", bus0.err_dat, 16'h00FF);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_stb", bus0.err_stb, 1);
         chk("bp_dat", bus0.err_dat, 16'h00FF);
         chk("bp_rdys", {bus0.res_rdy, bus0.tgt_rdy}, 0);
      end
      bus0.err_rdy = 1;
      tick();
      chk("bp_release_stb", bus0.err_stb, 0);
      chk("bp_release_rdy", bus0.res_rdy, 1);
      bus0.err_rdy = 0;

      // Table of single samples, including the target-first ordering case.
      for (int i = 0; i < 8; i++) begin
         x0 = m_xfers;
         run_sample(vecs[i].res, vecs[i].tgt, vecs[i].gap_r, vecs[i].gap_t, 1'b0, got);
         tick(); tick(); tick();
         chk($sformatf("vec%0d_err", i), got, vecs[i].exp);
         chk($sformatf("vec%0d_one_xfer", i), m_xfers - x0, 1);
      end

      // Two epochs: one mismatch, then all clean.
      do_reset();
      run_sample(8'd5, 8'd5, 0, 0, 1'b0, got);
      run_sample(8'd3, 8'd9, 0, 0, 1'b0, got);
      run_sample(8'd7, 8'd7, 0, 0, 1'b0, got);
      run_sample(8'd1, 8'd1, 0, 0, 1'b0, got);
      chk("ep1_done", done0, 0);
      chk("ep1_cnt", cnt0, STATS ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
         chk("ep2_done_early", done0, 0);
         run_sample(8'(i * 20), 8'(i * 20), 1, 0, 1'b0, got);
      end
      chk("ep2_done", done0, 1);
      chk("ep2_cnt", cnt0, STATS ? 1 : 0);

      // Asynchronous reset in the middle of SEND.
      bus0.res_stb = 1; bus0.res_dat = 8'h10;
      bus0.tgt_stb = 1; bus0.tgt_dat = 8'h20;
      bus0.err_rdy = 0;
      tick();
      bus0.res_stb = 0; bus0.tgt_stb = 0;
      wait_err(10, ok);
      chk("ar_reach_send", ok, 1);
      #2 rst = 0;
      #1;
      chk("ar_err_stb", bus0.err_stb, 0);
      chk("ar_err_dat", bus0.err_dat, 0);
      chk("ar_done", done0, 0);
      chk("ar_cnt", cnt0, 0);
      @(negedge clk);
      @(posedge clk); #3 rst = 1;
      tick();
      chk("ar_res_rdy", bus0.res_rdy, 1);
      chk("ar_tgt_rdy", bus0.tgt_rdy, 1);

      // Enable low with inputs pending, then with the error pending.
      bus0.tgt_stb = 1; bus0.tgt_dat = 8'h30;
      tick();
      bus0.tgt_stb = 0;
      bus0.res_stb = 1; bus0.res_dat = 8'h10;
      en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en0_rdys", {bus0.res_rdy, bus0.tgt_rdy}, 0);
         chk("en0_no_stb", bus0.err_stb, 0);
      end
      en = 1;
      tick();
      bus0.res_stb = 0;
      wait_err(10, ok);
      chk("en_reach_send", ok, 1);
      chk("en_err_dat", bus0.err_dat, 16'h0020);
      en = 0; bus0.err_rdy = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en0_send_stb", bus0.err_stb, 1);
         chk("en0_send_dat", bus0.err_dat, 16'h0020);
      end
      en = 1;
      tick();
      chk("en1_xfer", bus0.err_stb, 0);
      bus0.err_rdy = 0;

      // SCALE=7 instance.
      run7(8'hFF, 8'h00, 16'h8080);
      run7(8'h00, 8'hFF, 16'h7F80);
      chk("s7_cnt", cnt7, STATS ? 2 : 0);
      chk("s7_done", done7, 0);

      // Randomized samples with random enable and error backpressure.
      for (int i = 0; i < 60; i++) begin
         rr = 8'($urandom_range(0, 255));
         tt = ($urandom_range(0, 1) != 0) ? rr : 8'($urandom_range(0, 255));
         run_sample(rr, tt, $urandom_range(0, 4), $urandom_range(0, 4), 1'b1, got);
         chk("rand_err", got, model_err(int'(tt), int'(rr), 0));
      end
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
